alarm_ctrl: RTL and testbench

ALARM_CTRL -- requirements
Module: alarm_ctrl

---
 rtl/alarm_ctrl.sv | 125 ++++++++++++
 tb/tb_alarm_ctrl.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/alarm_ctrl.sv
// alarm_ctrl: intruder alarm FSM with exit/entry delays; define ALARM_SIREN_TIMEOUT_EN to let the siren time out back to ARMED
module alarm_ctrl #(
    parameter int EXIT_DLY   = 16,
    parameter int ENTRY_DLY  = 16,
    parameter int SIREN_TIME = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       alarm_set,
    input  logic       alarm_disarm,
    input  logic       alarm_stay,
    input  logic [1:0] doors,
    input  logic [2:0] windows,
    output logic       secure,
    output logic       armed,
    output logic       alarm,
    output logic       pending,
    output logic       arm_fail,
    output logic [2:0] state
);
    localparam logic [2:0] S_DIS = 3'd0, S_EXIT = 3'd1, S_ARM = 3'd2, S_ENTRY = 3'd3, S_ALARM = 3'd4;
    localparam logic [15:0] EXIT_LD  = 16'(EXIT_DLY - 1);
    localparam logic [15:0] ENTRY_LD = 16'(ENTRY_DLY - 1);
`ifdef ALARM_SIREN_TIMEOUT_EN
    localparam logic [15:0] ALARM_LD = 16'(SIREN_TIME - 1);
`else
    localparam logic [15:0] ALARM_LD = 16'd0;
`endif

    if (EXIT_DLY < 1 || EXIT_DLY > 65535 || ENTRY_DLY < 1 || ENTRY_DLY > 65535 ||
        SIREN_TIME < 1 || SIREN_TIME > 65535) begin : g_param_err
        $error("alarm_ctrl: delay parameters must be in 1..65535");
    end

    logic [2:0]  nxt;
    logic [15:0] cnt, cnt_nxt;
    logic        stay, stay_nxt, fail_nxt, armed_d, alarm_d, pending_d;
    logic        opening, win_open;

    assign opening  = |{doors, windows};
    assign win_open = |windows;

    // state, counter, stay latch and all outputs are registered together
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_DIS;
            cnt      <= '0;
            stay     <= 1'b0;
            secure   <= 1'b0;
            armed    <= 1'b0;
            alarm    <= 1'b0;
            pending  <= 1'b0;
            arm_fail <= 1'b0;
        end else begin
            state    <= nxt;
            cnt      <= cnt_nxt;
            stay     <= stay_nxt;
            secure   <= ~opening;
            armed    <= armed_d;
            alarm    <= alarm_d;
            pending  <= pending_d;
            arm_fail <= fail_nxt;
        end
    end

    // next state; the counter defaults to 0 so it never wraps and idles at 0
    always_comb begin
        nxt      = state;
        cnt_nxt  = '0;
        stay_nxt = stay;
        fail_nxt = 1'b0;
        if (alarm_disarm) begin
            nxt      = S_DIS;
            stay_nxt = 1'b0;
        end else begin
            case (state)
                S_DIS: if (alarm_set) begin
                    if (opening) begin
                        fail_nxt = 1'b1;
                    end else begin
                        stay_nxt = alarm_stay;
                        nxt      = alarm_stay ? S_ARM : S_EXIT;
                        cnt_nxt  = alarm_stay ? '0 : EXIT_LD;
                    end
                end
                S_EXIT: if (cnt == '0) begin
                    nxt     = opening ? S_ENTRY : S_ARM;
                    cnt_nxt = opening ? ENTRY_LD : '0;
                end else begin
                    cnt_nxt = cnt - 16'd1;
                end
                S_ARM: if (stay ? opening : win_open) begin
                    nxt     = S_ALARM;
                    cnt_nxt = ALARM_LD;
                end else if (|doors) begin
                    nxt     = S_ENTRY;
                    cnt_nxt = ENTRY_LD;
                end
                S_ENTRY: if (win_open || cnt == '0) begin
                    nxt     = S_ALARM;
                    cnt_nxt = ALARM_LD;
                end else begin
                    cnt_nxt = cnt - 16'd1;
                end
`ifdef ALARM_SIREN_TIMEOUT_EN
                S_ALARM: if (cnt == '0) nxt = S_ARM;
                         else cnt_nxt = cnt - 16'd1;
`else
                S_ALARM: nxt = S_ALARM;
`endif
                default: begin
                    nxt      = S_DIS;
                    stay_nxt = 1'b0;
                end
            endcase
        end
    end

    // output decode from the next state so the flops line up with state
    always_comb begin
        armed_d   = nxt != S_DIS;
        alarm_d   = nxt == S_ALARM;
        pending_d = nxt == S_EXIT || nxt == S_ENTRY;
    end
endmodule

// File: tb/tb_alarm_ctrl.sv
// tb_alarm_ctrl: directed + random checks of alarm_ctrl against a deadline-based reference model
module tb_alarm_ctrl;
    localparam int XD = 4, ND = 3, SD = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1, alarm_set = 1'b0, alarm_disarm = 1'b0, alarm_stay = 1'b0;
    logic [1:0] doors = '0;
    logic [2:0] windows = '0;
    logic       secure, armed, alarm, pending, arm_fail;
    logic [2:0] state;

    int   checks = 0, passed = 0, cyc = 0, m_st = 0, m_end = 0, n = 0;
    logic m_stay = 1'b0, m_fail = 1'b0, m_sec = 1'b0, seen = 1'b0;

    alarm_ctrl #(.EXIT_DLY(XD), .ENTRY_DLY(ND), .SIREN_TIME(SD)) dut (
        .clk(clk), .reset(reset), .alarm_set(alarm_set), .alarm_disarm(alarm_disarm),
        .alarm_stay(alarm_stay), .doors(doors), .windows(windows), .secure(secure),
        .armed(armed), .alarm(alarm), .pending(pending), .arm_fail(arm_fail), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s @edge %0d: got %0h expected %0h", tag, cyc, obs, exp);
    endtask

    // reference: each timed state records the edge number at which it expires
    task automatic model_edge();
        logic op = |{doors, windows};
        cyc++;
        m_fail = 1'b0;
        if (reset) begin
            m_st = 0; m_stay = 1'b0; m_sec = 1'b0;
        end else begin
            m_sec = !op;
            if (alarm_disarm) begin
                m_st = 0; m_stay = 1'b0;
            end else begin
                case (m_st)
                    0: if (alarm_set) begin
                        if (op) m_fail = 1'b1;
                        else begin m_stay = alarm_stay; m_st = alarm_stay ? 2 : 1; m_end = cyc + XD; end
                    end
                    1: if (cyc == m_end) begin
                        if (op) begin m_st = 3; m_end = cyc + ND; end else m_st = 2;
                    end
                    2: if (m_stay ? op : |windows) begin m_st = 4; m_end = cyc + SD; end
                       else if (|doors) begin m_st = 3; m_end = cyc + ND; end
                    3: if (|windows || cyc == m_end) begin m_st = 4; m_end = cyc + SD; end
`ifdef ALARM_SIREN_TIMEOUT_EN
                    4: if (cyc == m_end) m_st = 2;
`endif
                    default: ;
                endcase
            end
        end
    endtask

    task automatic step(input logic r, s, d, sy, input logic [1:0] dr, input logic [2:0] w);
        @(negedge clk);
        reset = r; alarm_set = s; alarm_disarm = d; alarm_stay = sy; doors = dr; windows = w;
        @(posedge clk);
        model_edge();
        #1;
        chk("state", 32'(state), 32'(m_st));
        chk("armed", 32'(armed), 32'(m_st != 0));
        chk("alarm", 32'(alarm), 32'(m_st == 4));
        chk("pending", 32'(pending), 32'(m_st == 1 || m_st == 3));
        chk("arm_fail", 32'(arm_fail), 32'(m_fail));
        chk("secure", 32'(secure), 32'(m_sec));
    endtask

    task automatic idle(input int k);
        repeat (k) step(0, 0, 0, 0, 2'b00, 3'b000);
    endtask

    initial begin
        step(1, 0, 0, 0, 2'b00, 3'b000);
        step(1, 1, 0, 0, 2'b01, 3'b000);
        chk("rst_state", 32'(state), 0);
        chk("rst_secure", 32'(secure), 0);
        idle(1);
        chk("secure_closed", 32'(secure), 1);
        // arm away, all closed: exit delay lasts XD cycles
        step(0, 1, 0, 0, 2'b00, 3'b000);
        n = 32'(pending);
        repeat (6) begin idle(1); n += 32'(pending); end
        chk("exit_len", n, XD);
        chk("armed_state", 32'(state), 2);
        // door opens: entry delay of ND cycles, door toggling does not restart it
        step(0, 0, 0, 0, 2'b01, 3'b000);
        n = 32'(state == 3);
        step(0, 0, 0, 0, 2'b00, 3'b000); n += 32'(state == 3);
        step(0, 0, 0, 0, 2'b10, 3'b000); n += 32'(state == 3);
        repeat (3) begin idle(1); n += 32'(state == 3); end
        chk("entry_len", n, ND);
        chk("entry_alarm", 32'(alarm), 1);
        step(0, 0, 1, 0, 2'b00, 3'b000);
        chk("disarm_state", 32'(state), 0);
        // entry delay aborted by disarm in its second cycle
        step(0, 1, 0, 0, 2'b00, 3'b000);
        idle(XD);
        step(0, 0, 0, 0, 2'b01, 3'b000);
        seen = alarm;
        step(0, 0, 1, 0, 2'b01, 3'b000);
        seen |= alarm;
        repeat (5) begin idle(1); seen |= alarm; end
        chk("abort_alarm", 32'(seen), 0);
        chk("abort_state", 32'(state), 0);
        // arm rejected with a door open
        step(0, 1, 0, 0, 2'b01, 3'b000);
        chk("fail_pulse", 32'(arm_fail), 1);
        chk("fail_armed", 32'(armed), 0);
        idle(1);
        chk("fail_clear", 32'(arm_fail), 0);
        // set with disarm is disarm only
        step(0, 1, 1, 0, 2'b00, 3'b000);
        chk("set_dis_state", 32'(state), 0);
        // stay mode: armed at once, window goes straight to alarm
        step(0, 1, 0, 1, 2'b00, 3'b000);
        chk("stay_state", 32'(state), 2);
        step(0, 0, 0, 0, 2'b00, 3'b110);
        chk("stay_alarm", 32'(alarm), 1);
        n = 32'(alarm);
        repeat (99) begin idle(1); n += 32'(alarm); end
`ifdef ALARM_SIREN_TIMEOUT_EN
        chk("siren_len", n, SD);
        chk("siren_back", 32'(state), 2);
`else
        chk("siren_len", n, 100);
`endif
        step(0, 0, 1, 0, 2'b00, 3'b000);
        // reset in the middle of entry delay
        step(0, 1, 0, 0, 2'b00, 3'b000);
        idle(XD);
        step(0, 0, 0, 0, 2'b01, 3'b000);
        idle(1);
        step(1, 0, 0, 0, 2'b01, 3'b000);
        chk("rst_mid", 32'({secure, armed, alarm, pending, arm_fail, state}), 0);
        // random traffic
        repeat (900) begin
            step(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 4) == 0),
                 1'($urandom_range(0, 24) == 0), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                 ($urandom_range(0, 9) == 0) ? 3'($urandom_range(1, 7)) : 3'b000);
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
